// File: rtl/busy_table.sv
// Physical-register busy table: one pending bit per physical register, set on rename
// allocation, cleared by writeback wakeup or a commit redirect, queried combinationally.
package busy_table_pkg;
  typedef struct packed {
    logic [15:0]      opid;
    logic [1:0][15:0] prsa;
    logic [15:0]      prda;
  } ren_bundle_t;

  typedef struct packed {
    logic [15:0] opid;
    logic [15:0] prda;
  } exe_bundle_t;

  typedef struct packed {
    logic redir;
  } com_bundle_t;
endpackage

module busy_table
  import busy_table_pkg::*;
#(
  parameter int rwd   = 4,
  parameter int ewd   = 4,
  parameter int cwd   = 4,
  parameter int prnum = 96,
  localparam int pw   = $clog2(prnum)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  ren_bundle_t [rwd-1:0]       ren_bundle,
  input  logic        [rwd-1:0]       accept,
  input  exe_bundle_t [ewd-1:0]       exe_bundle,
  input  com_bundle_t [cwd-1:0]       com_bundle,
  output logic        [rwd-1:0][1:0]  busy_resp,
  output logic        [pw:0]          busy_cnt
);

  localparam logic [15:0] PRN = 16'(prnum);

  logic [prnum-1:0] busy;
  logic [prnum-1:0] busy_next;
  logic [prnum-1:0] wk;
  logic [prnum-1:0] st;
  logic [pw:0]      cnt_next;
  logic [15:0]      qa;
  logic             qhit;

  // Out-of-range addresses are filtered before indexing, so the low pw bits are safe.
  always_comb begin
    wk = '0;
    st = '0;
    for (int j = 0; j < ewd; j++) begin
      if (exe_bundle[j].opid[15] && (exe_bundle[j].prda < PRN))
        wk[exe_bundle[j].prda[pw-1:0]] = 1'b1;
    end
    for (int i = 0; i < rwd; i++) begin
      if (ren_bundle[i].opid[15] && accept[i] &&
          (ren_bundle[i].prda < PRN) && (ren_bundle[i].prda != '0))
        st[ren_bundle[i].prda[pw-1:0]] = 1'b1;
    end
  end

  // Intra-bundle term ignores accept: lanes are accepted in order, so a younger lane is
  // dropped whenever an older producer lane is not accepted.
  always_comb begin
    busy_resp = '0;
    qa        = '0;
    qhit      = 1'b0;
    for (int i = 0; i < rwd; i++) begin
      for (int k = 0; k < 2; k++) begin
        qa   = ren_bundle[i].prsa[k];
        qhit = 1'b0;
        if (qa < PRN) begin
          qhit = busy[qa[pw-1:0]] & ~wk[qa[pw-1:0]];
          for (int j = 0; j < i; j++) begin
            if (ren_bundle[j].opid[15] && (ren_bundle[j].prda == qa) && (qa != '0))
              qhit = 1'b1;
          end
        end
        busy_resp[i][k] = ren_bundle[i].opid[15] & qhit;
      end
    end
  end

  // Set beats a same-cycle wakeup: the new allocation is the younger producer.
  always_comb begin
    if (com_bundle[0].redir)
      busy_next = '0;
    else
      busy_next = st | (busy & ~wk);
    cnt_next = '0;
    for (int r = 0; r < prnum; r++)
      cnt_next = cnt_next + (pw+1)'(busy_next[r]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_busy_table.sv
// Scoreboard bench for busy_table: directed cases from the expected behaviour, then a
// randomized phase checked against a small behavioural model of the table.
module tb_busy_table;
  import busy_table_pkg::*;

  localparam int RWD   = 4;
  localparam int EWD   = 4;
  localparam int CWD   = 4;
  localparam int PRNUM = 96;

  logic                       clk = 1'b0;
  logic                       rst;
  ren_bundle_t [RWD-1:0]      ren;
  logic        [RWD-1:0]      acc;
  exe_bundle_t [EWD-1:0]      exe;
  com_bundle_t [CWD-1:0]      com;
  logic        [RWD-1:0][1:0] resp;
  logic        [7:0]          cnt;

  int total = 0;
  int bad   = 0;
  bit mdl[PRNUM];

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t resp_q[$];
  sb_t cnt_q[$];

  busy_table #(.rwd(RWD), .ewd(EWD), .cwd(CWD), .prnum(PRNUM)) dut (
    .clk        (clk),
    .rst        (rst),
    .ren_bundle (ren),
    .accept     (acc),
    .exe_bundle (exe),
    .com_bundle (com),
    .busy_resp  (resp),
    .busy_cnt   (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ren = '0;
    acc = '0;
    exe = '0;
    com = '0;
  endtask

  task automatic rn(int l, int s0, int s1, int d, bit a);
    ren[l].opid    = 16'h8000;
    ren[l].prsa[0] = 16'(s0);
    ren[l].prsa[1] = 16'(s1);
    ren[l].prda    = 16'(d);
    acc[l]         = a;
  endtask

  task automatic ex(int l, int d);
    exe[l].opid = 16'h8000;
    exe[l].prda = 16'(d);
  endtask

  function automatic bit m_wk(int a);
    for (int j = 0; j < EWD; j++)
      if (exe[j].opid[15] && exe[j].prda == 16'(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_st(int a);
    if (a == 0) return 1'b0;
    for (int i = 0; i < RWD; i++)
      if (ren[i].opid[15] && acc[i] && ren[i].prda == 16'(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_resp();
    logic [7:0] r = '0;
    for (int i = 0; i < RWD; i++) begin
      for (int k = 0; k < 2; k++) begin
        int a = int'(ren[i].prsa[k]);
        bit v = 1'b0;
        if (ren[i].opid[15] && a < PRNUM) begin
          v = mdl[a] & !m_wk(a);
          for (int j = 0; j < i; j++)
            if (ren[j].opid[15] && int'(ren[j].prda) == a && a != 0) v = 1'b1;
        end
        r[i*2+k] = v;
      end
    end
    return r;
  endfunction

  function automatic int m_update();
    bit nx[PRNUM];
    int c = 0;
    for (int r = 0; r < PRNUM; r++) begin
      nx[r] = com[0].redir ? 1'b0 : (m_st(r) | (mdl[r] & !m_wk(r)));
      c += int'(nx[r]);
    end
    mdl = nx;
    return c;
  endfunction

  // Entered just after a rising edge with this cycle's inputs already driven.
  task automatic step(string tag, bit dir, logic [7:0] er, int ec);
    sb_t e;
    int  mc;
    e.tag = {tag, ".resp"};
    e.exp = dir ? 32'(er) : 32'(m_resp());
    resp_q.push_back(e);
    mc    = m_update();
    e.tag = {tag, ".cnt"};
    e.exp = dir ? 32'(ec) : 32'(mc);
    cnt_q.push_back(e);
    #2;
    e = resp_q.pop_front();
    chk(e.tag, 32'(resp), e.exp);
    @(posedge clk);
    #1;
    e = cnt_q.pop_front();
    chk(e.tag, 32'(cnt), e.exp);
    clr();
  endtask

  function automatic int raddr();
    int r = $urandom_range(0, 19);
    return (r < 16) ? r : 94 + (r - 16);
  endfunction

  initial begin
    rst = 1'b0;
    clr();
    foreach (mdl[r]) mdl[r] = 1'b0;
    @(posedge clk);
    #1;
    // In reset only intra-bundle hits are visible, and accepted sets are held off.
    rn(0, 0, 0, 3, 1);
    rn(1, 3, 0, 0, 0);
    #2;
    chk("rst_intra", 32'(resp), 32'h04);
    chk("rst_cnt", 32'(cnt), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_cnt", 32'(cnt), 0);
    rst = 1'b1;
    clr();

    rn(0, 0, 0, 5, 1);                        step("set5",       1, 8'h00, 1);
    rn(0, 5, 0, 0, 0);                        step("q5",         1, 8'h01, 1);
    rn(0, 5, 0, 0, 0); ex(2, 5);              step("wk5",        1, 8'h00, 0);
    rn(0, 5, 0, 0, 0);                        step("q5_clear",   1, 8'h00, 0);
    rn(0, 0, 0, 7, 0); rn(2, 0, 7, 0, 0);     step("intra",      1, 8'h20, 0);
    rn(0, 7, 7, 0, 0); rn(2, 0, 0, 7, 0);     step("intra_rev",  1, 8'h00, 0);
    rn(0, 0, 0, 0, 1); rn(1, 0, 0, 200, 1);
    rn(2, 0, 200, 0, 0);                      step("bounds",     1, 8'h00, 0);
    rn(0, 0, 200, 0, 0);                      step("bounds_q",   1, 8'h00, 0);
    rn(0, 0, 0, 9, 1); ex(0, 9);
    rn(1, 9, 0, 0, 0);                        step("set_wk9",    1, 8'h04, 1);
    rn(0, 9, 0, 0, 0);                        step("q9",         1, 8'h01, 1);
    rn(0, 9, 0, 9, 1); rn(1, 0, 0, 11, 1);
    ex(0, 9); com[0].redir = 1'b1;            step("redir",      1, 8'h00, 0);
    rn(0, 9, 11, 0, 0);                       step("post_redir", 1, 8'h00, 0);
    rn(0, 0, 0, 12, 1); rn(1, 12, 0, 12, 1);  step("dup12",      1, 8'h04, 1);
    for (int i = 0; i < 4; i++) rn(i, 0, 0, 20 + i, 1);
    step("fill_a", 1, 8'h00, 5);
    for (int i = 0; i < 4; i++) rn(i, 0, 0, 24 + i, 1);
    step("fill_b", 1, 8'h00, 9);
    rn(0, 0, 0, 28, 1);                       step("fill_c",     1, 8'h00, 10);
    rn(0, 12, 20, 0, 0);                      step("q_full",     1, 8'h03, 10);

    // Asynchronous reset pulse between edges.
    rn(0, 12, 20, 0, 0);
    rn(1, 28, 95, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_cnt", 32'(cnt), 0);
    chk("async_resp", 32'(resp), 0);
    foreach (mdl[r]) mdl[r] = 1'b0;
    #2 rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    chk("post_async_cnt", 32'(cnt), 0);
    rn(0, 12, 20, 0, 0);                      step("post_async_q", 1, 8'h00, 0);

    for (int n = 0; n < 300; n++) begin
      int na = $urandom_range(0, RWD);
      for (int i = 0; i < RWD; i++) begin
        if ($urandom_range(0, 3) != 0) rn(i, raddr(), raddr(), raddr(), 1'b0);
        acc[i] = (i < na);
      end
      for (int j = 0; j < EWD; j++)
        if ($urandom_range(0, 2) == 0) ex(j, raddr());
      com[0].redir = ($urandom_range(0, 24) == 0);
      step($sformatf("rnd%0d", n), 0, 8'h00, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
